// File: rtl/vmx_pkg.sv
// Shared constants for the vmatrix_pg text-mode pixel pipeline: register map,
// cursor modes, register reset values and the default 16-entry palette.
package vmx_pkg;

    localparam logic [1:0] REG_CURSOR  = 2'd0;
    localparam logic [1:0] REG_SHAPE   = 2'd1;
    localparam logic [1:0] REG_PALETTE = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    typedef enum logic [1:0] {
        CM_OFF    = 2'b00,
        CM_STEADY = 2'b01,
        CM_BLINK  = 2'b10,
        CM_BLINK2 = 2'b11
    } curs_mode_t;

    localparam logic [15:0] CURSOR_RST = 16'h0071;
    localparam logic [15:0] CTRL_RST   = 16'h0000;

    // Entry i sits at slice [i]; colour bits are {R,RI,G,GI,B,BI}.
    localparam logic [15:0][5:0] PAL_DEFAULT = {
        6'h3F, 6'h3C, 6'h33, 6'h30, 6'h0F, 6'h0C, 6'h03, 6'h15,
        6'h2A, 6'h28, 6'h22, 6'h20, 6'h0A, 6'h08, 6'h02, 6'h00
    };

endpackage

// File: rtl/vmx_palette.sv
// 16x6 colour palette. With VMX_PALETTE_WR_EN it is a bus-writable RAM with a
// pixel read port and a bus read port; otherwise a constant ROM of PAL_DEFAULT.
module vmx_palette
    import vmx_pkg::*;
(
`ifdef VMX_PALETTE_WR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] widx,
    input  logic [5:0] wdata,
    input  logic [3:0] bus_idx,
    output logic [5:0] bus_col,
`endif
    input  logic [3:0] pix_idx,
    output logic [5:0] pix_col
);

`ifdef VMX_PALETTE_WR_EN
    logic [15:0][5:0] mem;

    always_ff @(posedge clk) begin
        if (rst)     mem       <= PAL_DEFAULT;
        else if (we) mem[widx] <= wdata;
    end

    // Async reads: a write on the same edge as a lookup still shows the old entry.
    assign pix_col = mem[pix_idx];
    assign bus_col = mem[bus_idx];
`else
    assign pix_col = PAL_DEFAULT[pix_idx];
`endif

endmodule

// File: rtl/vmatrix_pg.sv
// Text-mode video matrix: serializes glyph rows into RGBI pixels with palette,
// cursor and attribute blink. Palette writability is selected by VMX_PALETTE_WR_EN.
module vmatrix_pg
    import vmx_pkg::*;
#(
    parameter int GLYPH_W    = 8,
    parameter int CURS_START = 14,
    parameter int CURS_END   = 15,
    parameter bit HSYNC_NEG  = 1'b1,
    parameter bit VSYNC_NEG  = 1'b1
) (
    input  logic        DOTCLOCK,
    input  logic        RST,
    input  logic        ph2,
    input  logic        sec_pulse,
    input  logic        DE,
    input  logic        HS,
    input  logic        VS,
    input  logic [4:0]  RA,
    input  logic        cursor,
    input  logic [15:0] VDI,
    input  logic [1:0]  REG_A,
    input  logic        W_REG,
    input  logic        R_REG,
    input  logic [15:0] DBI,
    output logic [15:0] DBO,
    output logic        hsync,
    output logic        vsync,
    output logic        R,
    output logic        RI,
    output logic        G,
    output logic        GI,
    output logic        B,
    output logic        BI
);

    logic [1:0]         w_det, r_det;
    logic               wr_go, rd_go;
    logic [3:0]         curs_col;
    curs_mode_t         curs_mode;
    logic [4:0]         c_start, c_end;
    logic [3:0]         pal_idx;
    logic [1:0]         ctrl;
    logic               sec_q, div, phase;
    logic [GLYPH_W-1:0] sr, load_val;
    logic [7:0]         attr;
    logic               cur_q;
    logic [3:0]         pix_idx;
    logic [5:0]         pix_col, rgb_q;
    logic               blank, cur_show, sec_rise;
    logic [15:0]        rd_val;
    logic               unused_dbi;

    assign unused_dbi = ^DBI[15:13];

    generate
        if (GLYPH_W == 9) begin : g_w9
            assign load_val = {VDI[7:0], ctrl[1] & VDI[0]};
        end else begin : g_w8
            assign load_val = VDI[7:0];
        end
    endgenerate

`ifdef VMX_PALETTE_WR_EN
    logic [5:0] bus_col;
    logic       pal_we;
    assign pal_we = wr_go && (REG_A == REG_PALETTE);
`endif

    vmx_palette u_pal (
`ifdef VMX_PALETTE_WR_EN
        .clk     (DOTCLOCK),
        .rst     (RST),
        .we      (pal_we),
        .widx    (DBI[11:8]),
        .wdata   (DBI[5:0]),
        .bus_idx (pal_idx),
        .bus_col (bus_col),
`endif
        .pix_idx (pix_idx),
        .pix_col (pix_col)
    );

    always_comb begin
        rd_val = 16'h0000;
        case (REG_A)
            REG_CURSOR:  rd_val = {8'h00, curs_col, 2'b00, curs_mode};
            REG_SHAPE:   rd_val = {3'b000, c_end, 3'b000, c_start};
`ifdef VMX_PALETTE_WR_EN
            REG_PALETTE: rd_val = {4'h0, pal_idx, 2'b00, bus_col};
`else
            REG_PALETTE: rd_val = {4'h0, pal_idx, 8'h00};
`endif
            default:     rd_val = {14'h0000, ctrl};
        endcase
    end

    assign sec_rise = sec_pulse & ~sec_q;
    assign cur_show = cur_q && (curs_mode != CM_OFF) && (RA >= c_start) && (RA <= c_end)
                      && ((curs_mode == CM_STEADY) || phase);

    always_comb begin
        blank   = ~DE;
        pix_idx = 4'h0;
        if (cur_show)
            pix_idx = curs_col;
        else if (ctrl[0]) begin
            // Attribute blink: bg[3] becomes a blink flag, only 8 background colours.
            if (sr[GLYPH_W-1] && !(attr[3] && !phase)) pix_idx = attr[7:4];
            else                                       pix_idx = {1'b0, attr[2:0]};
        end else
            pix_idx = sr[GLYPH_W-1] ? attr[7:4] : attr[3:0];
    end

    always_ff @(posedge DOTCLOCK) begin
        if (RST) begin
            w_det     <= 2'b00;
            r_det     <= 2'b00;
            wr_go     <= 1'b0;
            rd_go     <= 1'b0;
            curs_col  <= CURSOR_RST[7:4];
            curs_mode <= curs_mode_t'(CURSOR_RST[1:0]);
            c_start   <= 5'(CURS_START);
            c_end     <= 5'(CURS_END);
            pal_idx   <= 4'h0;
            ctrl      <= CTRL_RST[1:0];
            sec_q     <= 1'b0;
            div       <= 1'b0;
            phase     <= 1'b1;
            sr        <= '0;
            attr      <= 8'h00;
            cur_q     <= 1'b0;
            rgb_q     <= 6'h00;
            DBO       <= 16'h0000;
            hsync     <= HSYNC_NEG;
            vsync     <= VSYNC_NEG;
        end else begin
            w_det <= {w_det[0], W_REG};
            r_det <= {r_det[0], R_REG};
            wr_go <= (w_det == 2'b01);
            rd_go <= (r_det == 2'b01);

            if (rd_go) DBO <= rd_val;
            if (wr_go) begin
                case (REG_A)
                    REG_CURSOR: begin
                        curs_col  <= DBI[7:4];
                        curs_mode <= curs_mode_t'(DBI[1:0]);
                    end
                    REG_SHAPE: begin
                        c_end   <= DBI[12:8];
                        c_start <= DBI[4:0];
                    end
`ifdef VMX_PALETTE_WR_EN
                    REG_PALETTE: pal_idx <= DBI[11:8];
`endif
                    REG_CTRL:   ctrl <= DBI[1:0];
                    default: ;
                endcase
            end

            // Divider only runs in every-second-edge mode so it starts clean on entry.
            sec_q <= sec_pulse;
            if (curs_mode != CM_BLINK2) div <= 1'b0;
            else if (sec_rise)          div <= ~div;
            if (sec_rise && ((curs_mode != CM_BLINK2) || div)) phase <= ~phase;

            if (ph2) begin
                sr    <= DE ? load_val : '0;
                attr  <= DE ? VDI[15:8] : 8'h00;
                cur_q <= DE & cursor;
            end else
                sr <= {sr[GLYPH_W-2:0], 1'b0};

            rgb_q <= blank ? 6'h00 : pix_col;
            hsync <= HS ^ HSYNC_NEG;
            vsync <= VS ^ VSYNC_NEG;
        end
    end

    assign {R, RI, G, GI, B, BI} = rgb_q;

endmodule

// File: tb/tb_vmatrix_pg.sv
// Directed bench for vmatrix_pg: an 8-dot and a 9-dot instance share all inputs.
module tb_vmatrix_pg;

    logic        DOTCLOCK = 1'b0;
    logic        RST = 1'b1;
    logic        ph2 = 1'b0, sec_pulse = 1'b0, DE = 1'b0, HS = 1'b0, VS = 1'b0;
    logic [4:0]  RA = 5'd0;
    logic        cursor = 1'b0;
    logic [15:0] VDI = 16'h0000;
    logic [1:0]  REG_A = 2'd0;
    logic        W_REG = 1'b0, R_REG = 1'b0;
    logic [15:0] DBI = 16'h0000;

    logic [15:0] dbo8, dbo9;
    logic        hs8, vs8, hs9, vs9;
    logic        r8, ri8, g8, gi8, b8, bi8;
    logic        r9, ri9, g9, gi9, b9, bi9;
    logic [5:0]  col8, col9;

    int checks = 0;
    int errors = 0;

    assign col8 = {r8, ri8, g8, gi8, b8, bi8};
    assign col9 = {r9, ri9, g9, gi9, b9, bi9};

`ifdef VMX_PALETTE_WR_EN
    localparam logic [15:0] PAL_RD  = 16'h0515;
    localparam logic [5:0]  PAL5    = 6'h15;
`else
    localparam logic [15:0] PAL_RD  = 16'h0000;
    localparam logic [5:0]  PAL5    = 6'h22;
`endif

    always #5 DOTCLOCK = ~DOTCLOCK;

    vmatrix_pg #(.GLYPH_W(8)) u8 (
        .DOTCLOCK(DOTCLOCK), .RST(RST), .ph2(ph2), .sec_pulse(sec_pulse),
        .DE(DE), .HS(HS), .VS(VS), .RA(RA), .cursor(cursor), .VDI(VDI),
        .REG_A(REG_A), .W_REG(W_REG), .R_REG(R_REG), .DBI(DBI), .DBO(dbo8),
        .hsync(hs8), .vsync(vs8),
        .R(r8), .RI(ri8), .G(g8), .GI(gi8), .B(b8), .BI(bi8)
    );

    vmatrix_pg #(.GLYPH_W(9)) u9 (
        .DOTCLOCK(DOTCLOCK), .RST(RST), .ph2(ph2), .sec_pulse(sec_pulse),
        .DE(DE), .HS(HS), .VS(VS), .RA(RA), .cursor(cursor), .VDI(VDI),
        .REG_A(REG_A), .W_REG(W_REG), .R_REG(R_REG), .DBI(DBI), .DBO(dbo9),
        .hsync(hs9), .vsync(vs9),
        .R(r9), .RI(ri9), .G(g9), .GI(gi9), .B(b9), .BI(bi9)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge DOTCLOCK);
            #1;
        end
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [15:0] d);
        REG_A = a;
        DBI   = d;
        W_REG = 1'b1;
        cyc(4);
        W_REG = 1'b0;
        cyc(2);
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [15:0] d);
        REG_A = a;
        R_REG = 1'b1;
        cyc(4);
        d = dbo8;
        R_REG = 1'b0;
        cyc(2);
    endtask

    // After this returns, each further cyc(1) presents the next dot.
    task automatic load_cell(input logic [15:0] v);
        VDI = v;
        DE  = 1'b1;
        ph2 = 1'b1;
        cyc(1);
        ph2 = 1'b0;
    endtask

    task automatic sec_edge();
        sec_pulse = 1'b1;
        cyc(2);
        sec_pulse = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset();
        logic [15:0] d;
        RST = 1'b1;
        cyc(3);
        checks++; if (col8 !== 6'h00) begin errors++; $display("FAIL reset_rgb8 got %h exp 00", col8); end
        checks++; if (col9 !== 6'h00) begin errors++; $display("FAIL reset_rgb9 got %h exp 00", col9); end
        checks++; if (dbo8 !== 16'h0000) begin errors++; $display("FAIL reset_dbo got %h exp 0000", dbo8); end
        checks++; if ({hs8, vs8} !== 2'b11) begin errors++; $display("FAIL reset_sync got %b exp 11", {hs8, vs8}); end
        RST = 1'b0;
        cyc(2);
        reg_rd(2'd0, d);
        checks++; if (d !== 16'h0071) begin errors++; $display("FAIL reset_cursor_reg got %h exp 0071", d); end
        reg_rd(2'd1, d);
        checks++; if (d !== 16'h0F0E) begin errors++; $display("FAIL reset_shape_reg got %h exp 0F0E", d); end
        reg_rd(2'd3, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_ctrl_reg got %h exp 0000", d); end
    endtask

    task automatic test_pixels();
        logic [5:0] e;
        HS = 1'b0;
        cyc(1);
        checks++; if (hs8 !== 1'b1) begin errors++; $display("FAIL hsync_idle got %b exp 1", hs8); end
        HS = 1'b1;
        load_cell(16'h1F81);
        checks++; if (hs8 !== 1'b0) begin errors++; $display("FAIL hsync_active got %b exp 0", hs8); end
        for (int d = 0; d < 8; d++) begin
            cyc(1);
            e = (d == 0 || d == 7) ? 6'h02 : 6'h3F;
            checks++; if (col8 !== e) begin errors++; $display("FAIL pix_1f81 dot%0d got %h exp %h", d, col8, e); end
        end
        HS = 1'b0;
    endtask

    task automatic test_cursor();
        logic [5:0] e;
        reg_wr(2'd1, 16'h0C0A);
        reg_wr(2'd0, 16'h00A1);
        cursor = 1'b1;
        RA = 5'd11;
        load_cell(16'h1F81);
        for (int d = 0; d < 8; d++) begin
            cyc(1);
            checks++; if (col8 !== 6'h0C) begin errors++; $display("FAIL cursor_on dot%0d got %h exp 0C", d, col8); end
        end
        RA = 5'd13;
        load_cell(16'h1F81);
        for (int d = 0; d < 8; d++) begin
            cyc(1);
            e = (d == 0 || d == 7) ? 6'h02 : 6'h3F;
            checks++; if (col8 !== e) begin errors++; $display("FAIL cursor_outside dot%0d got %h exp %h", d, col8, e); end
        end
        // Start row above end row: cursor never shows.
        reg_wr(2'd1, 16'h0A0C);
        RA = 5'd11;
        load_cell(16'h1F81);
        cyc(1);
        checks++; if (col8 !== 6'h02) begin errors++; $display("FAIL cursor_inverted got %h exp 02", col8); end
        reg_wr(2'd1, 16'h0C0A);
    endtask

    task automatic test_blink();
        reg_wr(2'd0, 16'h00A2);
        cursor = 1'b1;
        RA = 5'd11;
        load_cell(16'h1F81);
        cyc(9);
        checks++; if (col8 !== 6'h0C) begin errors++; $display("FAIL blink10_start got %h exp 0C", col8); end
        sec_edge();
        checks++; if (col8 !== 6'h3F) begin errors++; $display("FAIL blink10_edge1 got %h exp 3F", col8); end
        sec_edge();
        checks++; if (col8 !== 6'h0C) begin errors++; $display("FAIL blink10_edge2 got %h exp 0C", col8); end
        reg_wr(2'd0, 16'h00A3);
        sec_edge();
        checks++; if (col8 !== 6'h0C) begin errors++; $display("FAIL blink11_edge1 got %h exp 0C", col8); end
        sec_edge();
        checks++; if (col8 !== 6'h3F) begin errors++; $display("FAIL blink11_edge2 got %h exp 3F", col8); end
        sec_edge();
        checks++; if (col8 !== 6'h3F) begin errors++; $display("FAIL blink11_edge3 got %h exp 3F", col8); end
        sec_edge();
        checks++; if (col8 !== 6'h0C) begin errors++; $display("FAIL blink11_edge4 got %h exp 0C", col8); end
        reg_wr(2'd0, 16'h0070);
        cursor = 1'b0;
    endtask

    task automatic test_attr_blink();
        reg_wr(2'd3, 16'h0001);
        load_cell(16'h9AFF);
        cyc(1);
        checks++; if (col8 !== 6'h03) begin errors++; $display("FAIL attr_fg_phase1 got %h exp 03", col8); end
        load_cell(16'h9A00);
        cyc(1);
        checks++; if (col8 !== 6'h08) begin errors++; $display("FAIL attr_bg_masked got %h exp 08", col8); end
        sec_edge();
        load_cell(16'h9AFF);
        cyc(1);
        checks++; if (col8 !== 6'h08) begin errors++; $display("FAIL attr_fg_phase0 got %h exp 08", col8); end
        sec_edge();
        load_cell(16'h9AFF);
        cyc(1);
        checks++; if (col8 !== 6'h03) begin errors++; $display("FAIL attr_fg_phase1b got %h exp 03", col8); end
        reg_wr(2'd3, 16'h0000);
        load_cell(16'h9A00);
        cyc(1);
        checks++; if (col8 !== 6'h0C) begin errors++; $display("FAIL attr_off_bg got %h exp 0C", col8); end
    endtask

    task automatic test_glyph9();
        logic [5:0] e;
        reg_wr(2'd3, 16'h0002);
        load_cell(16'h1F01);
        for (int d = 0; d < 9; d++) begin
            cyc(1);
            e = (d >= 7) ? 6'h02 : 6'h3F;
            checks++; if (col9 !== e) begin errors++; $display("FAIL w9_repl dot%0d got %h exp %h", d, col9, e); end
        end
        reg_wr(2'd3, 16'h0000);
        load_cell(16'h1F01);
        for (int d = 0; d < 9; d++) begin
            cyc(1);
            e = (d == 7) ? 6'h02 : 6'h3F;
            checks++; if (col9 !== e) begin errors++; $display("FAIL w9_norepl dot%0d got %h exp %h", d, col9, e); end
        end
    endtask

    task automatic test_palette();
        logic [15:0] d;
        reg_wr(2'd2, 16'h0515);
        reg_rd(2'd2, d);
        checks++; if (d !== PAL_RD) begin errors++; $display("FAIL pal_read got %h exp %h", d, PAL_RD); end
        load_cell(16'h55FF);
        cyc(1);
        checks++; if (col8 !== PAL5) begin errors++; $display("FAIL pal_pixel got %h exp %h", col8, PAL5); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        REG_A = 2'd1;
        DBI   = 16'h0305;
        W_REG = 1'b1;
        R_REG = 1'b1;
        cyc(2);
        checks++; if (dbo8 !== PAL_RD) begin errors++; $display("FAIL rd_latency_early got %h exp %h", dbo8, PAL_RD); end
        cyc(1);
        checks++; if (dbo8 !== 16'h0C0A) begin errors++; $display("FAIL rd_wr_same_edge got %h exp 0C0A", dbo8); end
        W_REG = 1'b0;
        R_REG = 1'b0;
        cyc(2);
        reg_rd(2'd1, d);
        checks++; if (d !== 16'h0305) begin errors++; $display("FAIL wr_after_collide got %h exp 0305", d); end
    endtask

    task automatic test_reset_midline();
        logic [15:0] d;
        HS = 1'b1;
        VS = 1'b1;
        load_cell(16'h1F81);
        cyc(1);
        checks++; if (col8 !== 6'h02) begin errors++; $display("FAIL midline_pre got %h exp 02", col8); end
        RST = 1'b1;
        cyc(1);
        checks++; if (col8 !== 6'h00) begin errors++; $display("FAIL midline_rgb got %h exp 00", col8); end
        checks++; if ({hs8, vs8} !== 2'b11) begin errors++; $display("FAIL midline_sync got %b exp 11", {hs8, vs8}); end
        checks++; if (dbo8 !== 16'h0000) begin errors++; $display("FAIL midline_dbo got %h exp 0000", dbo8); end
        RST = 1'b0;
        HS = 1'b0;
        VS = 1'b0;
        DE = 1'b0;
        cyc(2);
        reg_rd(2'd1, d);
        checks++; if (d !== 16'h0F0E) begin errors++; $display("FAIL midline_shape got %h exp 0F0E", d); end
        reg_rd(2'd0, d);
        checks++; if (d !== 16'h0071) begin errors++; $display("FAIL midline_cursor got %h exp 0071", d); end
    endtask

    initial begin
        test_reset();
        test_pixels();
        test_cursor();
        test_blink();
        test_attr_blink();
        test_glyph9();
        test_palette();
        test_back_to_back();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vmatrix_pg.md
# vmatrix_pg

Parametrised successor to the text-mode video matrix. Each character cell it takes attribute and glyph-row data from video RAM and serializes it into pixels. It applies a bus-programmable palette, a programmable cursor shape with blink modes, optional attribute blink and optional 9-pixel cells. It sits between the CRTC timing generator (DE/HS/VS/RA/cursor) and the RGBI output pins, and its registers are reachable over the same 16-bit controller data bus.

## Interface
Parameters:
- GLYPH_W, 8 — cell width in dots; 8 or 9.
- CURS_START, 14 — reset value of the cursor start row.
- CURS_END, 15 — reset value of the cursor end row.
- HSYNC_NEG, 1 — invert HS on output.
- VSYNC_NEG, 1 — invert VS on output.

Ports:
- DOTCLOCK  in  1  dot clock; the only clock.
- RST  in  1  reset, synchronous, active-high.
- ph2  in  1  character-load strobe; high one DOTCLOCK per cell.
- sec_pulse  in  1  blink time base; rising edge detected internally.
- DE, HS, VS  in  1 each  display enable and syncs from the CRTC.
- RA  in  5  character row address.
- cursor  in  1  cursor at the current cell.
- VDI  in  16  {attr[7:0], glyph_row[7:0]}; attr = {fg[3:0], bg[3:0]}.
- REG_A  in  2  register select.
- W_REG  in  1  register write request; level, edge detected.
- R_REG  in  1  register read request; level, edge detected.
- DBI  in  16  write data.
- DBO  out  16  read data.
- hsync, vsync  out  1 each  polarity-adjusted syncs.
- R, RI, G, GI, B, BI  out  1 each  pixel colour.

## Operation
- Registers:
  - 0 CURSOR: [7:4] cursor colour, [1:0] mode (00 off, 01 steady, 10 blink on every sec_pulse edge, 11 blink every second edge). Reset 0x0071.
  - 1 SHAPE: [12:8] end row, [4:0] start row. Reset {CURS_END, CURS_START}.
  - 2 PALETTE: write [11:8] index, [5:0] colour; read returns {4'b0, idx, 2'b0, pal[idx]} for the last-written index (reset idx 0).
  - 3 CTRL: [0] attribute blink enable, [1] 9th-column replicate. Reset 0.
  - Unused bits read 0.
- Bus access:
  - W_REG and R_REG each pass through a 2-bit shift detector; action fires when the detector reads 01.
  - Read: DBO <= selected register.
  - Write: register <= DBI.
  - DBO holds its value between reads.
- Palette:
  - 16×6 entries, {R,RI,G,GI,B,BI}.
  - Reset contents: 00,02,08,0A,20,22,28,2A,15,03,0C,0F,30,33,3C,3F.
- Cell load (ph2=1):
  - If DE: shift register (GLYPH_W bits) <= glyph_row, plus for GLYPH_W=9 an extra LSB = CTRL[1] ? glyph_row[0] : 0.
  - Also latch attr and cursor.
  - If DE=0: shift register, attr and cursor are all cleared.
  - When ph2=0, the shift register shifts left and fills with 0.
- Blink phase:
  - Toggles on each qualifying sec_pulse rising edge; mode 11 uses a 1-bit divider.
  - Resets to 1 (visible).
- Pixel select, evaluated on the current MSB, in priority order:
  1. DE=0 → 0.
  2. Cursor latched, mode≠00, start≤RA≤end, and (mode=01 or phase=1) → pal[cursor colour].
  3. CTRL[0]=1: background index = {0, bg[2:0]}. If bg[3]=1 and phase=0, the pixel uses the background colour.
  4. Otherwise, MSB=1 → pal[fg], else pal[bg].
- Start > end: the cursor never shows.

## Timing
- Pixel path:
  - The glyph MSB loaded at edge N appears on R..BI after edge N+1; one output register stage.
  - hsync/vsync are delayed by the same single stage to stay aligned: hsync <= HS ^ HSYNC_NEG.
- Register access:
  - Write takes effect 3 edges after W_REG rises: 2 detector edges plus the update edge.
  - Read data is valid on DBO 3 edges after R_REG rises.
- Simultaneous events:
  - Read and write firing on the same edge: DBO gets the pre-write value.
  - A palette write on the same edge as a pixel lookup: the lookup uses the old entry.
- Reset (any cycle, including mid-line):
  - All registers return to their reset values and detectors clear.
  - R..BI=0, DBO=0, hsync=HSYNC_NEG, vsync=VSYNC_NEG.

## Configuration
- VMX_PALETTE_WR_EN:
  - Defined: the palette is writable through register 2 as above.
  - Undefined: the palette is a constant ROM of the reset table; writes to register 2 are ignored and reads return only the index field.

## Structure
- Package vmx_pkg holds:
  - register address constants;
  - the default palette array;
  - cursor mode encodings;
  - reset values for CURSOR and CTRL.
- Sub-module vmx_palette (16×6 storage, write port, one async read port, plus a second async read port for the bus) is compiled as RAM or ROM per VMX_PALETTE_WR_EN.

## Test plan
- Reset, then VDI=0x1F81 with DE=1 and ph2 pulse, GLYPH_W=8 → dots: bit7 fg pal[1]=02, six dots bg pal[0xF]=3F, bit0 fg 02; hsync=~HS one edge later.
- Write SHAPE=0x0C0A, CURSOR=0x00A1; cursor=1, RA=11 → every dot = pal[0xA]=0C; RA=13 → normal glyph.
- Mode 10: two sec_pulse edges → cursor hidden after first and shown after second; mode 11 → toggles every second edge.
- CTRL=1, attr=0x9A, glyph=0xFF → fg shown while phase=1 and bg pal[2]=08 while phase=0.
- GLYPH_W=9, CTRL=2, glyph=0x01 → dots 8 and 9 both fg; CTRL=0 → dot 9 bg.
- Palette write 0x0515 then read reg 2 → DBO=0x0515; W_REG and R_REG rising together → old value read; RST mid-line → all outputs at reset values next edge.
